pong_ball_engine: RTL and testbench

PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

---
 rtl/pong_ball_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve/play/score FSM advanced once per frame, plus a ball/paddle/centre-line pixel renderer.
// Latency: rgb, hsync_out, vsync_out and activevideo_out are one clock behind x/y/syncs; game state moves one clock after vsync falls.
// Backpressure: none; the pixel stream is consumed every clock and the game logic never stalls it.
//
// Ports:
//   clock, reset                  sole clock; synchronous active-high reset
//   x, y, activevideo, hsync,     pixel position and timing from the sync generator
//   vsync                         (syncs active-low)
//   paddle_l_y, paddle_r_y        paddle top rows, sampled on each frame tick
//   rgb                           {R,G,B} 4 bits each, registered
//   hsync_out, vsync_out,         timing inputs delayed one clock to line up with rgb
//   activevideo_out
//   score_l, score_r              BCD scores, saturating at 9
module pong_ball_engine #(
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_H     = 64,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        activevideo,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [9:0]  paddle_l_y,
    input  logic [9:0]  paddle_r_y,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        activevideo_out,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r
);

    localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

    // Ball geometry is kept in 11-bit signed so that "x - SPEED" style
    // look-ahead tests never wrap below zero.
    localparam logic signed [10:0] SPD     = 11'(SPEED);
    localparam logic signed [10:0] BSZ     = 11'(BALL_SIZE);
    localparam logic signed [10:0] PHS     = 11'(PADDLE_H);
    localparam logic signed [10:0] CEN_X   = 11'(320 - BALL_SIZE / 2);
    localparam logic signed [10:0] CEN_Y   = 11'(240 - BALL_SIZE / 2);
    localparam logic signed [10:0] FIELD_W = 11'sd640;
    localparam logic signed [10:0] FIELD_H = 11'sd480;
    localparam logic signed [10:0] L_FACE  = 11'sd24;   // first column right of left paddle
    localparam logic signed [10:0] R_FACE  = 11'sd616;  // first column of right paddle

    localparam logic [9:0]  PAD_MAX = 10'(480 - PADDLE_H);
    localparam logic [10:0] PHU     = 11'(PADDLE_H);

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_BALL   = 12'hFFF;
    localparam logic [11:0] RGB_PADDLE = 12'h0F0;
    localparam logic [11:0] RGB_CENTRE = 12'h888;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      serve_cnt, serve_cnt_nxt;
    logic signed [10:0] ball_x, ball_y, ball_x_nxt, ball_y_nxt;
    logic               dx_neg, dy_neg, dx_neg_nxt, dy_neg_nxt;
    logic [3:0]         score_l_nxt, score_r_nxt;

    logic               vsync_prev;
    logic               frame_tick;

    logic [9:0]         pad_l, pad_r;          // committed paddle tops used for drawing
    logic [9:0]         pad_l_smp, pad_r_smp;  // clamped paddle inputs
    logic signed [10:0] pl_top, pr_top;
    logic               rows_hit_l, rows_hit_r;

    logic signed [10:0] px, py;
    logic               on_ball, on_pad_l, on_pad_r, on_centre;
    logic [11:0]        rgb_nxt;

    // ------------------------------------------------------------------
    // Paddle clamping and row overlap against the current ball rows
    // ------------------------------------------------------------------
    assign pad_l_smp = (paddle_l_y > PAD_MAX) ? PAD_MAX : paddle_l_y;
    assign pad_r_smp = (paddle_r_y > PAD_MAX) ? PAD_MAX : paddle_r_y;
    assign pl_top    = $signed({1'b0, pad_l_smp});
    assign pr_top    = $signed({1'b0, pad_r_smp});

    // Half-open intervals [top, top+H) intersect iff each starts before the other ends.
    assign rows_hit_l = (ball_y < pl_top + PHS) && (pl_top < ball_y + BSZ);
    assign rows_hit_r = (ball_y < pr_top + PHS) && (pr_top < ball_y + BSZ);

    // ------------------------------------------------------------------
    // Next-state logic, evaluated every clock but committed only on frame_tick
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        serve_cnt_nxt = serve_cnt;
        ball_x_nxt    = ball_x;
        ball_y_nxt    = ball_y;
        dx_neg_nxt    = dx_neg;
        dy_neg_nxt    = dy_neg;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;

        case (state)
            SERVE: begin
                ball_x_nxt = CEN_X;
                ball_y_nxt = CEN_Y;
                if (serve_cnt == SERVE_LAST) begin
                    serve_cnt_nxt = '0;
                    state_nxt     = PLAY;
                end else begin
                    serve_cnt_nxt = serve_cnt + 1'b1;
                end
            end

            PLAY: begin
                // Vertical axis: walls only.
                if (dy_neg) begin
                    if (ball_y < SPD) begin
                        ball_y_nxt = '0;
                        dy_neg_nxt = 1'b0;
                    end else begin
                        ball_y_nxt = ball_y - SPD;
                    end
                end else begin
                    if (ball_y + BSZ + SPD > FIELD_H) begin
                        ball_y_nxt = FIELD_H - BSZ;
                        dy_neg_nxt = 1'b1;
                    end else begin
                        ball_y_nxt = ball_y + SPD;
                    end
                end

                // Horizontal axis: miss beats paddle, paddle beats free motion.
                // On a miss the ball is left where it is; SCORED re-centres it.
                if (dx_neg) begin
                    if (ball_x < SPD) begin
                        score_r_nxt = (score_r < 4'd9) ? score_r + 4'd1 : score_r;
                        state_nxt   = SCORED;
                    end else if ((ball_x >= L_FACE) && (ball_x - SPD < L_FACE) && rows_hit_l) begin
                        ball_x_nxt = L_FACE;
                        dx_neg_nxt = 1'b0;
                    end else begin
                        ball_x_nxt = ball_x - SPD;
                    end
                end else begin
                    if (ball_x + BSZ + SPD > FIELD_W) begin
                        score_l_nxt = (score_l < 4'd9) ? score_l + 4'd1 : score_l;
                        state_nxt   = SCORED;
                    end else if ((ball_x + BSZ <= R_FACE) && (ball_x + BSZ + SPD > R_FACE) && rows_hit_r) begin
                        ball_x_nxt = R_FACE - BSZ;
                        dx_neg_nxt = 1'b1;
                    end else begin
                        ball_x_nxt = ball_x + SPD;
                    end
                end
            end

            SCORED: begin
                // A miss can only happen while travelling toward the side that
                // missed, so keeping dx already serves toward that player.
                state_nxt  = SERVE;
                dx_neg_nxt = dx_neg;
                ball_x_nxt = CEN_X;
                ball_y_nxt = CEN_Y;
            end

            default: begin
                state_nxt = SERVE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame tick, game state and paddle registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_prev <= 1'b1;
            frame_tick <= 1'b0;
            state      <= SERVE;
            serve_cnt  <= '0;
            ball_x     <= CEN_X;
            ball_y     <= CEN_Y;
            dx_neg     <= 1'b0;
            dy_neg     <= 1'b0;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            pad_l      <= 10'd0;
            pad_r      <= 10'd0;
        end else begin
            vsync_prev <= vsync;
            frame_tick <= vsync_prev & ~vsync;
            if (frame_tick) begin
                state     <= state_nxt;
                serve_cnt <= serve_cnt_nxt;
                ball_x    <= ball_x_nxt;
                ball_y    <= ball_y_nxt;
                dx_neg    <= dx_neg_nxt;
                dy_neg    <= dy_neg_nxt;
                score_l   <= score_l_nxt;
                score_r   <= score_r_nxt;
                pad_l     <= pad_l_smp;
                pad_r     <= pad_r_smp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel renderer; reads only registers committed at the last tick
    // ------------------------------------------------------------------
    assign px = $signed({1'b0, x});
    assign py = $signed({1'b0, y});

    assign on_ball   = (px >= ball_x) && (px < ball_x + BSZ) &&
                       (py >= ball_y) && (py < ball_y + BSZ);
    assign on_pad_l  = (x >= 10'd16) && (x <= 10'd23) &&
                       (y >= pad_l) && ({1'b0, y} < {1'b0, pad_l} + PHU);
    assign on_pad_r  = (x >= 10'd616) && (x <= 10'd623) &&
                       (y >= pad_r) && ({1'b0, y} < {1'b0, pad_r} + PHU);
    assign on_centre = ((x == 10'd318) || (x == 10'd319)) && !y[3];

    always_comb begin
        rgb_nxt = RGB_BLACK;
        if (!activevideo) begin
            rgb_nxt = RGB_BLACK;
        end else if (on_ball) begin
            rgb_nxt = RGB_BALL;
        end else if (on_pad_l || on_pad_r) begin
            rgb_nxt = RGB_PADDLE;
        end else if (on_centre) begin
            rgb_nxt = RGB_CENTRE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb             <= RGB_BLACK;
            hsync_out       <= 1'b1;
            vsync_out       <= 1'b1;
            activevideo_out <= 1'b0;
        end else begin
            rgb             <= rgb_nxt;
            hsync_out       <= hsync;
            vsync_out       <= vsync;
            activevideo_out <= activevideo;
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
// Ball position is observed through the pixel stream: two opposite corner pixels of the ball must be white.
module tb_pong_ball_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        activevideo, hsync, vsync;
    logic [9:0]  paddle_l_y, paddle_r_y;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, activevideo_out;
    logic [3:0]  score_l, score_r;

    int n_cmp = 0;
    int n_bad = 0;

    pong_ball_engine dut (
        .clock           (clock),
        .reset           (reset),
        .x               (x),
        .y               (y),
        .activevideo     (activevideo),
        .hsync           (hsync),
        .vsync           (vsync),
        .paddle_l_y      (paddle_l_y),
        .paddle_r_y      (paddle_r_y),
        .rgb             (rgb),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .activevideo_out (activevideo_out),
        .score_l         (score_l),
        .score_r         (score_r)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        av;
        logic        hs;
        logic [11:0] exp_rgb;
    } pix_vec_t;

    localparam int NV = 19;
    pix_vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One frame tick: vsync low for a clock, then high for a clock.
    task automatic tick(input int n);
        repeat (n) begin
            vsync = 1'b0;
            @(negedge clock);
            vsync = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic check_ball(input string name, input int ex, input int ey);
        hsync       = 1'b1;
        activevideo = 1'b1;
        x = 10'(ex);
        y = 10'(ey);
        @(negedge clock);
        chk({name, "_topleft"}, int'(rgb), 12'hFFF);
        x = 10'(ex + 7);
        y = 10'(ey + 7);
        @(negedge clock);
        chk({name, "_botright"}, int'(rgb), 12'hFFF);
        activevideo = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ball centred at (316,236); left paddle rows 300..363 (x 16..23);
        // right paddle input 470 clamps to 416 -> rows 416..479 (x 616..623).
        vecs[0]  = '{10'd316, 10'd236, 1'b1, 1'b1, 12'hFFF};
        vecs[1]  = '{10'd323, 10'd243, 1'b1, 1'b1, 12'hFFF};
        vecs[2]  = '{10'd324, 10'd236, 1'b1, 1'b1, 12'h000};
        vecs[3]  = '{10'd316, 10'd236, 1'b0, 1'b1, 12'h000};
        vecs[4]  = '{10'd318, 10'd236, 1'b1, 1'b1, 12'hFFF};
        vecs[5]  = '{10'd318, 10'd0,   1'b1, 1'b1, 12'h888};
        vecs[6]  = '{10'd319, 10'd7,   1'b1, 1'b1, 12'h888};
        vecs[7]  = '{10'd319, 10'd8,   1'b1, 1'b1, 12'h000};
        vecs[8]  = '{10'd318, 10'd16,  1'b1, 1'b0, 12'h888};
        vecs[9]  = '{10'd320, 10'd0,   1'b1, 1'b1, 12'h000};
        vecs[10] = '{10'd16,  10'd300, 1'b1, 1'b1, 12'h0F0};
        vecs[11] = '{10'd23,  10'd363, 1'b1, 1'b0, 12'h0F0};
        vecs[12] = '{10'd23,  10'd364, 1'b1, 1'b1, 12'h000};
        vecs[13] = '{10'd15,  10'd300, 1'b1, 1'b1, 12'h000};
        vecs[14] = '{10'd616, 10'd416, 1'b1, 1'b1, 12'h0F0};
        vecs[15] = '{10'd623, 10'd479, 1'b1, 1'b1, 12'h0F0};
        vecs[16] = '{10'd616, 10'd415, 1'b0, 1'b0, 12'h000};
        vecs[17] = '{10'd624, 10'd420, 1'b1, 1'b1, 12'h000};
        vecs[18] = '{10'd616, 10'd450, 1'b0, 1'b1, 12'h000};

        // ---------------- reset values ----------------
        reset       = 1'b1;
        x           = 10'd316;
        y           = 10'd236;
        activevideo = 1'b1;
        hsync       = 1'b0;
        vsync       = 1'b1;
        paddle_l_y  = 10'd300;
        paddle_r_y  = 10'd470;
        repeat (2) @(negedge clock);
        chk("rst_rgb", int'(rgb), 12'h000);
        chk("rst_hsync_out", int'(hsync_out), 1);
        chk("rst_vsync_out", int'(vsync_out), 1);
        chk("rst_av_out", int'(activevideo_out), 0);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_score_r", int'(score_r), 0);
        reset       = 1'b0;
        activevideo = 1'b0;
        hsync       = 1'b1;
        @(negedge clock);

        // ---------------- serve then play ----------------
        check_ball("serve_t0", 316, 236);
        tick(59);
        check_ball("serve_t59", 316, 236);
        tick(1);
        check_ball("serve_t60", 316, 236);

        // Pixel vectors: one-clock latency on rgb, hsync_out, activevideo_out.
        for (int i = 0; i < NV; i++) begin
            x           = vecs[i].px;
            y           = vecs[i].py;
            activevideo = vecs[i].av;
            hsync       = vecs[i].hs;
            @(negedge clock);
            chk($sformatf("pix%0d_rgb", i), int'(rgb), int'(vecs[i].exp_rgb));
            chk($sformatf("pix%0d_hsync_out", i), int'(hsync_out), int'(vecs[i].hs));
            chk($sformatf("pix%0d_av_out", i), int'(activevideo_out), int'(vecs[i].av));
        end
        chk("pix_vsync_out", int'(vsync_out), 1);
        hsync       = 1'b1;
        activevideo = 1'b0;

        // Rally 1, k = play ticks: x = 316+2k, y = 236+2k.
        tick(1);
        check_ball("play_k1", 318, 238);
        // Bottom wall holds y at 472 (k=118,119, flip on 119); k=147 prior
        // (608,418): rows 418..425 meet clamped paddle 416..479 -> bounce.
        tick(146);
        check_ball("rpaddle_k147", 608, 416);
        tick(1);
        check_ball("rpaddle_k148", 606, 414);
        // Top wall: y reaches 0 at k=355, flips at k=356.
        tick(208);
        check_ball("topwall_k356", 190, 0);
        tick(1);
        check_ball("topwall_k357", 188, 2);
        // k=440 prior x=24, rows 166..173 vs left paddle 300..363: no bounce.
        tick(83);
        check_ball("lnobounce_k440", 22, 168);
        tick(11);
        check_ball("lmiss_pre_k451", 0, 190);
        chk("lmiss_pre_score_r", int'(score_r), 0);
        tick(1);
        chk("lmiss_score_r", int'(score_r), 1);
        chk("lmiss_score_l", int'(score_l), 0);
        tick(1);
        check_ball("scored_to_serve", 316, 236);

        // Rally 2: serve toward the left (who missed), dy still +2.
        paddle_l_y = 10'd400;
        tick(59);
        check_ball("serve2_t59", 316, 236);
        tick(1);
        tick(1);
        check_ball("play2_m1", 314, 238);
        // m=147 prior (24,418): rows 418..425 meet 400..463 -> bounce at x=24.
        tick(146);
        check_ball("lpaddle_m147", 24, 416);
        tick(1);
        check_ball("lpaddle_m148", 26, 414);

        // ---------------- reset mid-play ----------------
        x           = 10'd26;
        y           = 10'd414;
        activevideo = 1'b1;
        hsync       = 1'b0;
        vsync       = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        chk("midrst_rgb", int'(rgb), 12'h000);
        chk("midrst_hsync_out", int'(hsync_out), 1);
        chk("midrst_vsync_out", int'(vsync_out), 1);
        chk("midrst_av_out", int'(activevideo_out), 0);
        chk("midrst_score_r", int'(score_r), 0);
        // vsync edges while in reset must not count as frames.
        vsync = 1'b1;
        @(negedge clock);
        vsync = 1'b0;
        @(negedge clock);
        vsync = 1'b1;
        @(negedge clock);
        reset       = 1'b0;
        activevideo = 1'b0;
        hsync       = 1'b1;
        @(negedge clock);
        check_ball("postrst_centre", 316, 236);

        // ---------------- score saturation ----------------
        // Paddle rows 100..163 never meet the ball at the right paddle face
        // (prior rows are 418..425 or 54..61 in alternating rallies).
        paddle_r_y = 10'd100;
        tick(60);
        check_ball("postrst_t60", 316, 236);
        tick(1);
        check_ball("postrst_k1", 318, 238);
        tick(157);
        chk("rmiss1_pre_score_l", int'(score_l), 0);
        tick(1);
        chk("rmiss1_score_l", int'(score_l), 1);
        // Each later rally: 1 SCORED + 60 SERVE + 159 PLAY ticks.
        for (int r = 2; r <= 9; r++) begin
            tick(220);
            chk($sformatf("rmiss%0d_score_l", r), int'(score_l), r);
        end
        tick(220);
        chk("rmiss10_score_l_sat", int'(score_l), 9);
        chk("rmiss10_score_r", int'(score_r), 0);
        tick(1);
        check_ball("rmiss10_serve", 316, 236);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
